// File: rtl/xbar_switch_allocator.sv
// Per-output round-robin wormhole switch allocator for the 5-port router crossbar (N,S,E,W,L).
// Latency: a request locks its output on the edge it is seen; the first flit moves the next cycle.
// Backpressure: out_ready_i low or an owner bubble holds the lock with pop_o/grant_valid_o at 0.
module xbar_switch_allocator (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_i,
  input  logic [14:0] dest_i,
  input  logic [4:0]  tail_i,
  input  logic [4:0]  out_ready_i,
  output logic [4:0]  pop_o,
  output logic [4:0]  grant_valid_o,
  output logic [14:0] sel_o,
  output logic [4:0]  busy_o,
  output logic        bad_dest_o
);

  localparam int NPORT = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Per-output FSM state, owning input and round-robin pointer.
  state_e     r_state     [NPORT];
  state_e     w_state_nxt [NPORT];
  logic [2:0] r_owner     [NPORT];
  logic [2:0] w_owner_nxt [NPORT];
  logic [2:0] r_ptr       [NPORT];
  logic [2:0] w_ptr_nxt   [NPORT];
  logic       r_bad_dest;

  // Decoded per-input destination and ownership.
  logic [2:0] w_dest      [NPORT];
  logic [4:0] w_is_owner;

  // w_cand[j][k]: input k competes for output j this cycle.
  logic [4:0] w_cand      [NPORT];
  // w_pick[j] = {found, winner index}.
  logic [3:0] w_pick      [NPORT];
  logic [4:0] w_xfer;
  logic       w_bad_any;

  // First set bit of cand scanning ptr+1, ptr+2, ... modulo NPORT, so the
  // input named by ptr (the previous winner) has the lowest priority.
  function automatic logic [3:0] rr_pick(input logic [4:0] cand, input logic [2:0] ptr);
    logic [3:0] res;
    int         c;
    res = '0;
    for (int i = 1; i <= NPORT; i++) begin
      c = (int'(ptr) + i) % NPORT;
      if (!res[3] && cand[c]) begin
        res = {1'b1, c[2:0]};
      end
    end
    return res;
  endfunction

  // Split the packed destination bus and mark every input that currently owns an output.
  always_comb begin
    w_is_owner = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_dest[k] = dest_i[3*k +: 3];
    end
    for (int j = 0; j < NPORT; j++) begin
      if (r_state[j] == ST_LOCKED) begin
        w_is_owner[r_owner[j]] = 1'b1;
      end
    end
  end

  // Candidate sets, per-output winners, transfer strobes and the invalid-destination detect.
  // Owners are excluded from candidacy, so no two outputs can ever pick the same input.
  always_comb begin
    w_bad_any = 1'b0;
    w_xfer    = '0;
    for (int j = 0; j < NPORT; j++) begin
      w_cand[j] = '0;
    end
    for (int k = 0; k < NPORT; k++) begin
      for (int j = 0; j < NPORT; j++) begin
        w_cand[j][k] = req_i[k] & ~w_is_owner[k] & (w_dest[k] == 3'(j));
      end
      if (req_i[k] && !w_is_owner[k] && (w_dest[k] >= 3'd5)) begin
        w_bad_any = 1'b1;
      end
    end
    for (int j = 0; j < NPORT; j++) begin
      w_pick[j] = rr_pick(w_cand[j], r_ptr[j]);
      w_xfer[j] = (r_state[j] == ST_LOCKED) & req_i[r_owner[j]] & out_ready_i[j];
    end
  end

  // Next-state logic: IDLE locks to the round-robin winner; LOCKED releases after the tail moves.
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      w_state_nxt[j] = r_state[j];
      w_owner_nxt[j] = r_owner[j];
      w_ptr_nxt[j]   = r_ptr[j];
      case (r_state[j])
        ST_IDLE: begin
          if (w_pick[j][3]) begin
            w_owner_nxt[j] = w_pick[j][2:0];
            w_state_nxt[j] = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_xfer[j] && tail_i[r_owner[j]]) begin
            w_state_nxt[j] = ST_IDLE;
            w_ptr_nxt[j]   = r_owner[j];
          end
        end
        default: begin
          w_state_nxt[j] = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; reset drops every lock at once and gives input 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NPORT; j++) begin
        r_state[j] <= ST_IDLE;
        r_owner[j] <= 3'd0;
        r_ptr[j]   <= 3'd4;
      end
      r_bad_dest <= 1'b0;
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        r_state[j] <= w_state_nxt[j];
        r_owner[j] <= w_owner_nxt[j];
        r_ptr[j]   <= w_ptr_nxt[j];
      end
      r_bad_dest <= w_bad_any;
    end
  end

  // Crossbar selects and busy flags come from registers; pops follow the transfer strobes.
  always_comb begin
    pop_o         = '0;
    sel_o         = '0;
    busy_o        = '0;
    grant_valid_o = w_xfer;
    for (int j = 0; j < NPORT; j++) begin
      sel_o[3*j +: 3] = r_owner[j];
      busy_o[j]       = (r_state[j] == ST_LOCKED);
      if (w_xfer[j]) begin
        pop_o[r_owner[j]] = 1'b1;
      end
    end
  end

  assign bad_dest_o = r_bad_dest;

endmodule

// File: tb/tb_xbar_switch_allocator.sv
// Bench for xbar_switch_allocator: directed scenarios plus randomized traffic vs a reference model.
// Inputs change 1 ns after the rising edge; outputs are compared on the falling edge.
// Flit sources dequeue on every observed pop, so backpressure comes from out_ready_i and hold masks.
module tb_xbar_switch_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  req_i;
  logic [14:0] dest_i;
  logic [4:0]  tail_i;
  logic [4:0]  out_ready_i;
  logic [4:0]  pop_o;
  logic [4:0]  grant_valid_o;
  logic [14:0] sel_o;
  logic [4:0]  busy_o;
  logic        bad_dest_o;

  xbar_switch_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .dest_i       (dest_i),
    .tail_i       (tail_i),
    .out_ready_i  (out_ready_i),
    .pop_o        (pop_o),
    .grant_valid_o(grant_valid_o),
    .sel_o        (sel_o),
    .busy_o       (busy_o),
    .bad_dest_o   (bad_dest_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Flit sources: remaining flits of the head packet and its destination.
  int         rem [5];
  int         dst [5];
  logic [4:0] hold;

  // Reference model: per-output lock flag, owner, last-winner pointer.
  int   m_locked [5];
  int   m_owner  [5];
  int   m_ptr    [5];
  logic m_bad;

  logic [4:0]  pop_seen;
  logic [4:0]  gv_seen;
  logic [14:0] sel_seen;

  int gsrc[$];
  int gcyc[$];
  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
  int wh_exp [5] = '{1, 1, 1, 1, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 5; k++) begin
      req_i[k]          = (rem[k] > 0) && !hold[k];
      tail_i[k]         = (rem[k] == 1);
      dest_i[3*k +: 3]  = 3'(dst[k]);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 5; j++) begin
      m_locked[j] = 0;
      m_owner[j]  = 0;
      m_ptr[j]    = 4;
    end
    m_bad = 1'b0;
  endtask

  // Expected outputs for the current cycle from model state and current inputs.
  task automatic check_model();
    logic [4:0]  e_pop;
    logic [4:0]  e_gv;
    logic [4:0]  e_busy;
    logic [14:0] e_sel;
    e_pop  = '0;
    e_gv   = '0;
    e_busy = '0;
    e_sel  = '0;
    for (int j = 0; j < 5; j++) begin
      e_sel[3*j +: 3] = 3'(m_owner[j]);
      if (m_locked[j] != 0) begin
        e_busy[j] = 1'b1;
        if (req_i[m_owner[j]] && out_ready_i[j]) begin
          e_gv[j]             = 1'b1;
          e_pop[m_owner[j]]   = 1'b1;
        end
      end
    end
    chk("model_pop", 32'(pop_o), 32'(e_pop));
    chk("model_grant", 32'(grant_valid_o), 32'(e_gv));
    chk("model_busy", 32'(busy_o), 32'(e_busy));
    chk("model_sel", 32'(sel_o), 32'(e_sel));
    chk("model_bad", 32'(bad_dest_o), 32'(m_bad));
  endtask

  // Advance the model across one clock edge using the inputs that were stable before it.
  task automatic model_step();
    int   own_of [5];
    bit   xf     [5];
    int   c;
    int   d;
    bit   found;
    for (int k = 0; k < 5; k++) own_of[k] = -1;
    for (int j = 0; j < 5; j++) if (m_locked[j] != 0) own_of[m_owner[j]] = j;
    for (int j = 0; j < 5; j++) begin
      xf[j] = (m_locked[j] != 0) && req_i[m_owner[j]] && out_ready_i[j];
    end
    m_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = int'(dest_i[3*k +: 3]);
      if (req_i[k] && own_of[k] < 0 && d >= 5) m_bad = 1'b1;
    end
    for (int j = 0; j < 5; j++) begin
      if (m_locked[j] != 0) begin
        if (xf[j] && tail_i[m_owner[j]]) begin
          m_locked[j] = 0;
          m_ptr[j]    = m_owner[j];
        end
      end else begin
        found = 1'b0;
        for (int i = 1; i <= 5; i++) begin
          c = (m_ptr[j] + i) % 5;
          if (!found && req_i[c] && own_of[c] < 0 && int'(dest_i[3*c +: 3]) == j) begin
            found       = 1'b1;
            m_locked[j] = 1;
            m_owner[j]  = c;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    pop_seen = pop_o;
    gv_seen  = grant_valid_o;
    sel_seen = sel_o;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (pop_seen[k] && rem[k] > 0) rem[k]--;
    end
    drive();
  endtask

  initial begin
    rst         = 1'b1;
    hold        = '0;
    out_ready_i = '1;
    req_i       = '0;
    tail_i      = '0;
    dest_i      = '0;
    for (int k = 0; k < 5; k++) begin
      rem[k] = 0;
      dst[k] = 0;
    end
    drive();
    model_reset();

    // Reset state.
    #12;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_pop", 32'(pop_o), 32'h0);
    chk("rst_grant", 32'(grant_valid_o), 32'h0);
    chk("rst_bad", 32'(bad_dest_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First grant: input 0 single flit to E.
    rem[0] = 1;
    dst[0] = 2;
    drive();
    tick();
    chk("first_busy", 32'(busy_o[2]), 32'h1);
    chk("first_sel", 32'(sel_o[8:6]), 32'h0);
    chk("first_pop", 32'(pop_o), 32'h01);
    chk("first_grant", 32'(grant_valid_o), 32'h04);
    tick();
    chk("first_release", 32'(busy_o[2]), 32'h0);
    chk("first_nopop", 32'(pop_o), 32'h0);

    // Round robin: inputs 0, 1, 3 stream single-flit packets to L.
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || k == 1 || k == 3) begin
        rem[k] = 1;
        dst[k] = 4;
      end
    end
    drive();
    gsrc.delete();
    gcyc.delete();
    for (int n = 0; n < 40 && gsrc.size() < 6; n++) begin
      tick();
      if (gv_seen[4]) begin
        gsrc.push_back(int'(sel_seen[14:12]));
        gcyc.push_back(cyc);
      end
      if (gsrc.size() < 6) begin
        if (rem[0] == 0) rem[0] = 1;
        if (rem[1] == 0) rem[1] = 1;
        if (rem[3] == 0) rem[3] = 1;
        drive();
      end
    end
    rem[0] = 0;
    rem[1] = 0;
    rem[3] = 0;
    drive();
    chk("rr_count", 32'(gsrc.size()), 32'd6);
    for (int i = 0; i < gsrc.size() && i < 6; i++) begin
      chk("rr_order", 32'(gsrc[i]), 32'(rr_exp[i]));
      if (i > 0) chk("rr_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    end

    // Wormhole: input 1 sends 4 flits to E, input 2 requests E one cycle later.
    rem[1] = 4;
    dst[1] = 2;
    drive();
    tick();
    rem[2] = 1;
    dst[2] = 2;
    drive();
    gsrc.delete();
    gcyc.delete();
    for (int n = 0; n < 20 && (rem[1] > 0 || rem[2] > 0); n++) begin
      tick();
      if (gv_seen[2]) begin
        gsrc.push_back(int'(sel_seen[8:6]));
        gcyc.push_back(cyc);
      end
      if (pop_seen[2]) chk("wh_hold", 32'(rem[1]), 32'd0);
    end
    chk("wh_count", 32'(gsrc.size()), 32'd5);
    for (int i = 0; i < gsrc.size() && i < 5; i++) begin
      chk("wh_order", 32'(gsrc[i]), 32'(wh_exp[i]));
      if (i > 0) chk("wh_gap", 32'(gcyc[i] - gcyc[i-1]), (i == 4) ? 32'd2 : 32'd1);
    end

    // Backpressure then bubble on input 0 -> W.
    rem[0] = 6;
    dst[0] = 3;
    drive();
    tick();
    tick();
    tick();
    out_ready_i[3] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("bp_grant", 32'(gv_seen[3]), 32'h0);
      chk("bp_pop", 32'(pop_seen[0]), 32'h0);
      chk("bp_busy", 32'(busy_o[3]), 32'h1);
    end
    out_ready_i[3] = 1'b1;
    hold[0] = 1'b1;
    drive();
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("bub_grant", 32'(gv_seen[3]), 32'h0);
      chk("bub_pop", 32'(pop_seen[0]), 32'h0);
      chk("bub_busy", 32'(busy_o[3]), 32'h1);
    end
    hold[0] = 1'b0;
    drive();
    chk("bp_left", 32'(rem[0]), 32'd4);
    begin
      int n;
      n = 0;
      while (rem[0] > 0 && n < 20) begin
        tick();
        n++;
      end
      chk("bp_resume_cycles", 32'(n), 32'd4);
    end
    chk("bp_release", 32'(busy_o[3]), 32'h0);

    // Parallel transfers plus a stuck invalid destination on input 4.
    rem[0] = 1; dst[0] = 1;
    rem[1] = 1; dst[1] = 0;
    rem[2] = 1; dst[2] = 4;
    rem[3] = 1; dst[3] = 3;
    rem[4] = 1000; dst[4] = 6;
    drive();
    tick();
    chk("par_pop", 32'(pop_o), 32'h0F);
    chk("par_grant", 32'(grant_valid_o), 32'h1B);
    chk("par_bad", 32'(bad_dest_o), 32'h1);
    tick();
    chk("par_release", 32'(busy_o), 32'h0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("inv_nopop", 32'(pop_seen[4]), 32'h0);
      chk("inv_bad", 32'(bad_dest_o), 32'h1);
    end
    rem[4] = 0;
    drive();
    tick();
    tick();
    chk("inv_clear", 32'(bad_dest_o), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 5; k++) begin
        if (rem[k] == 0 && ($urandom % 3) == 0) begin
          rem[k] = $urandom_range(4, 1);
          dst[k] = (($urandom % 8) == 0) ? $urandom_range(7, 5) : $urandom_range(4, 0);
        end else if (dst[k] >= 5 && rem[k] > 0 && ($urandom % 4) == 0) begin
          rem[k] = 0;
        end
        hold[k] = (($urandom % 5) == 0);
      end
      out_ready_i = 5'($urandom);
      drive();
      tick();
    end

    // Drain the random traffic.
    hold        = '0;
    out_ready_i = '1;
    for (int k = 0; k < 5; k++) if (dst[k] >= 5) rem[k] = 0;
    drive();
    for (int n = 0; n < 200 && (rem[0] + rem[1] + rem[2] + rem[3] + rem[4]) > 0; n++) begin
      tick();
    end
    chk("drain_left", 32'(rem[0] + rem[1] + rem[2] + rem[3] + rem[4]), 32'd0);
    chk("drain_busy", 32'(busy_o), 32'h0);

    // Asynchronous reset mid-packet.
    rem[0] = 3;
    dst[0] = 1;
    drive();
    tick();
    tick();
    chk("arst_pre_pop", 32'(pop_o[0]), 32'h1);
    chk("arst_pre_busy", 32'(busy_o[1]), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_pop", 32'(pop_o), 32'h0);
    chk("arst_grant", 32'(grant_valid_o), 32'h0);
    model_reset();
    for (int k = 0; k < 5; k++) rem[k] = 0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
